// File: rtl/tt_input_debounce.sv
// tt_input_debounce: synchronizes, debounces and edge-detects the user
// switch/button inputs, and buffers one change event for a downstream consumer.
// Latency: SYNC_STAGES + STABLE_TICKS - 1 edges from raw_in to outputs with
// sample_en held high.
// Backpressure: single-entry event buffer. A change arriving while an event is
// pending sets evt_overflow. It is merged into the pending event when
// INPUT_DEBOUNCE_MERGE_EN is defined, and dropped from the event path otherwise.
//
// Optional feature macro: INPUT_DEBOUNCE_MERGE_EN (undefined by default).
//
// Ports:
//   clk, reset        tile clock; asynchronous active-high reset
//   sample_en         debounce sample tick, qualifies counting
//   raw_in            asynchronous switch inputs
//   state_out         debounced level
//   rise_pulse        one-cycle pulse per bit on a debounced 0->1 transition
//   fall_pulse        one-cycle pulse per bit on a debounced 1->0 transition
//   evt_valid/ready   change-event handshake
//   evt_state         snapshot of state_out at the event
//   evt_rise/fall     accumulated rise/fall masks of the event
//   evt_overflow      a change arrived while the event was pending
module tt_input_debounce #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] state_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_state,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             evt_overflow
);

  // A synchronizer shallower than two flops is not metastability-safe.
  // Such a request is clamped rather than honoured.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [NS-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0]         r_state;
  logic [WIDTH-1:0]         r_rise;
  logic [WIDTH-1:0]         r_fall;
  logic                     r_evt_valid;
  logic [WIDTH-1:0]         r_evt_state;
  logic [WIDTH-1:0]         r_evt_rise;
  logic [WIDTH-1:0]         r_evt_fall;
  logic                     r_evt_overflow;

  logic [WIDTH-1:0]         w_sync;
  logic [WIDTH-1:0][CW-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]         w_tog;
  logic [WIDTH-1:0]         w_state_nxt;
  logic [WIDTH-1:0]         w_rise;
  logic [WIDTH-1:0]         w_fall;
  logic                     w_change;
  logic                     w_accept;

  // ---------------------------------------------------------------------------
  // Synchronizer chain: stage 0 captures raw_in, the last stage feeds debounce.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= raw_in;
      for (int s = 1; s < NS; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[NS-1];

  // ---------------------------------------------------------------------------
  // Per-bit debounce counters.
  // The counter measures how many consecutive ticks the synchronized input has
  // disagreed with the debounced level. Any agreement, even between ticks,
  // restarts the count, so a bounce never accumulates toward a flip.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tog     = '0;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_sync[i] == r_state[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (sample_en) begin
        if (r_cnt[i] == LAST) begin
          w_tog[i]     = 1'b1;
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + ONE;
        end
      end
    end
  end

  assign w_state_nxt = r_state ^ w_tog;
  assign w_rise      = w_tog & ~r_state;
  assign w_fall      = w_tog &  r_state;
  assign w_change    = |w_tog;
  assign w_accept    = r_evt_valid & evt_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-entry event buffer.
  // The buffer is fed from the same-cycle toggle vector, not from the
  // registered pulses. This makes evt_valid rise on the same edge as
  // state_out and the pulses. The accept decision uses only registered
  // evt_valid, so evt_ready never reaches an output combinationally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_valid    <= 1'b0;
      r_evt_state    <= '0;
      r_evt_rise     <= '0;
      r_evt_fall     <= '0;
      r_evt_overflow <= 1'b0;
    end else if (w_change && (!r_evt_valid || evt_ready)) begin
      // Buffer is free, or is draining this edge: load a fresh event.
      r_evt_valid    <= 1'b1;
      r_evt_state    <= w_state_nxt;
      r_evt_rise     <= w_rise;
      r_evt_fall     <= w_fall;
      r_evt_overflow <= 1'b0;
    end else if (w_change) begin
      // Event pending and stalled: the consumer must learn it missed a change.
`ifdef INPUT_DEBOUNCE_MERGE_EN
      r_evt_state    <= w_state_nxt;
      r_evt_rise     <= r_evt_rise | w_rise;
      r_evt_fall     <= r_evt_fall | w_fall;
`endif
      r_evt_overflow <= 1'b1;
    end else if (w_accept) begin
      // Masks are left stale; they carry no meaning while evt_valid is low.
      r_evt_valid    <= 1'b0;
      r_evt_overflow <= 1'b0;
    end
  end

  assign state_out    = r_state;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign evt_valid    = r_evt_valid;
  assign evt_state    = r_evt_state;
  assign evt_rise     = r_evt_rise;
  assign evt_fall     = r_evt_fall;
  assign evt_overflow = r_evt_overflow;

endmodule

// File: doc/tt_input_debounce.md
# tt_input_debounce

Synchronizes, debounces and edge-detects the 8 user switch/button inputs of the Tiny Tapeout tile before design logic uses them. It is the input-side counterpart to the display output path. It runs on the fast tile clock, with a sample tick typically taken from the clock divider. It presents a debounced level vector, single-cycle edge pulses, and a one-entry valid/ready change-event buffer for a downstream controller.

## Interface
- WIDTH, 8: number of input bits.
- SYNC_STAGES, 2: flip-flop synchronizer depth, minimum 2.
- STABLE_TICKS, 4: number of consecutive sample ticks a bit must differ from its debounced level before it flips; range 1..255.
- clk  in  1  tile clock.
- reset  in  1  reset, asynchronous, active-high.
- sample_en  in  1  debounce sample tick; qualifies counting.
- raw_in  in  WIDTH  asynchronous switch inputs.
- state_out  out  WIDTH  debounced level.
- rise_pulse  out  WIDTH  one-cycle pulse per bit on a debounced 0->1 transition.
- fall_pulse  out  WIDTH  one-cycle pulse per bit on a debounced 1->0 transition.
- evt_valid  out  1  change event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_state  out  WIDTH  snapshot of state_out at the event.
- evt_rise  out  WIDTH  accumulated rise mask.
- evt_fall  out  WIDTH  accumulated fall mask.
- evt_overflow  out  1  a change occurred while an event was pending; sticky until that event is accepted.

## Operation
- Reset values: synchronizer 0, state_out 0, all counters 0, rise_pulse/fall_pulse 0, evt_valid 0, evt_state/evt_rise/evt_fall 0, evt_overflow 0.
- Synchronizer: each raw_in bit passes through SYNC_STAGES flops; the last stage is sync[i].
- Per-bit counter, width clog2(STABLE_TICKS+1):
  - If sync[i] == state_out[i], the counter clears to 0, regardless of sample_en.
  - Otherwise, on sample_en the counter increments.
  - When sample_en arrives with counter == STABLE_TICKS-1, state_out[i] toggles, the counter clears, and the matching rise_pulse or fall_pulse bit is set for exactly one cycle.
  - A bounce back to the old level before the threshold clears the counter and produces no pulse.
- Change cycle: any bit with a pulse. Multiple bits may change in the same cycle and are reported in one event.
- Event buffer, one entry:
  - Change cycle with buffer empty, or with evt_valid && evt_ready: load evt_state = new state_out, evt_rise = rise_pulse, evt_fall = fall_pulse, evt_overflow = 0, evt_valid = 1.
  - evt_valid && evt_ready with no change: evt_valid = 0 and evt_overflow = 0. Masks hold their stale value; they are don't-care while evt_valid is 0.
  - Change while evt_valid && !evt_ready: handled per Configuration; evt_overflow is set to 1 in both variants.
- Handshake: transfer happens when evt_valid && evt_ready at a rising edge. evt_valid and all evt_* fields hold stable until transfer, except under merge (see Configuration).
- If raw_in is high during reset, it is reported as a rise once reset releases and the debounce delay elapses.

## Timing
- Latency with sample_en tied high: raw_in change set up before edge k gives state_out, the pulse, and evt_valid after edge k+SYNC_STAGES+STABLE_TICKS-1. For the default parameters this is edge k+5.
- With gated sample_en, latency is SYNC_STAGES cycles plus the time needed to see STABLE_TICKS qualifying ticks.
- Outputs are all registered; there are no combinational paths from input to output, including evt_ready to evt_valid.
- Throughput: one event per cycle when evt_ready is held high.
- If reset asserts mid-debounce or with an event pending, all state clears immediately and the pending event is lost.

## Configuration
- INPUT_DEBOUNCE_MERGE_EN defined: a change arriving while an event is pending is merged into it. evt_state updates to the current state_out, evt_rise |= rise_pulse, evt_fall |= fall_pulse, and evt_overflow is set to 1. This is the one case where pending fields may change before transfer.
- Macro undefined: the new change is dropped from the event path. Pending fields stay frozen and only evt_overflow is set to 1. state_out and the pulses still update normally.

## Test plan
- Clean press, defaults, sample_en=1: raw_in 0x00->0x01 before edge 10 -> state_out=0x01, rise_pulse=0x01 for one cycle, evt_valid=1 with evt_rise=0x01, all after edge 15.
- Bounce: bit 3 high for 3 cycles, low for 1, then high steadily -> no pulse during the bounce; single rise once 4 consecutive post-sync high samples are seen.
- Gated tick: sample_en every 4th cycle, bit 0 rises -> state_out changes on the 4th qualifying tick; no change in between.
- Back-pressure: evt_ready=0, bit 0 rises, then bit 1 rises -> with macro: evt_state=0x03, evt_rise=0x03, evt_overflow=1; without macro: evt_state=0x01, evt_rise=0x01, evt_overflow=1. After evt_ready pulses: evt_valid=0, evt_overflow=0.
- Accept and new change in the same cycle, evt_ready=1: the new event loads, evt_valid stays 1, evt_overflow=0.
- Reset mid-debounce at counter=2: all outputs return to 0 asynchronously; with raw_in held at 0xFF, a 0xFF rise event appears 5 edges after release.
